tinker_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the Tinker core, replacing the single-register PC-plus-4 fetcher. It issues in-order requests to a variable-latency instruction memory, keeps up to DEPTH fetched instructions with their PCs in a prefetch queue, and serves them to decode through a valid/ready handshake. A branch redirect flushes the queue and discards memory responses that were already in flight.

---
 rtl/tinker_fetch_pkg.sv | 12 +
 rtl/tinker_fetch_queue_if.sv | 29 ++
 rtl/tinker_sync_fifo.sv | 44 ++++
 rtl/tinker_fetch_queue.sv | 59 +++++
 tb/tb_tinker_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_fetch_pkg.sv
// tinker_fetch_pkg: shared constants and queue entry type for the Tinker fetch front end
// Ports: none (package). Entry fields are sized for the widest supported PC/instruction.
package tinker_fetch_pkg;
  localparam logic [63:0] DEF_RESET_PC = 64'h2000;
  localparam int DEF_PC_INC = 4;
  localparam int PC_W = 64;
  localparam int IW = 32;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/tinker_fetch_queue_if.sv
// tinker_fetch_queue_if: memory request/response, redirect and decode handshake bundle
// master: fetch queue side (drives requests and queue head); slave: memory/decode side.
interface tinker_fetch_queue_if #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic imem_req_ready;
  logic imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic out_ready;
  logic [CW-1:0] count;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, count,
    input imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, out_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/tinker_sync_fifo.sv
// tinker_sync_fifo: power-of-two ring buffer of fetch entries with show-ahead head
// Ports: clk, reset (async), flush (sync clear, wins over push/pop), push/din, pop, head, count.
module tinker_sync_fifo
  import tinker_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !flush;
  assign do_pop = pop && count != '0 && !flush;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // Credit accounting upstream must make a push into a full buffer impossible unless it pops too.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    do_push |-> (count != CW'(DEPTH) || do_pop));
endmodule

// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: credit-limited instruction prefetcher with redirect flush and stale-response drop
// Ports: clk, reset (async, active-high), bus (master modport: imem request/response,
// redirect, decode valid/ready head, occupancy count).
module tinker_fetch_queue
  import tinker_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int DEPTH = 4,
  parameter int ADDR_W = PC_W,
  parameter int INSTR_W = IW,
  parameter int PC_INC = DEF_PC_INC
) (
  input logic clk,
  input logic reset,
  tinker_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] inflight, stale, inflight_next, count;
  logic accept, resp, push, pop;
  fetch_entry_t head;
  // Outstanding requests hold a queue slot, so queue plus in-flight never exceeds DEPTH.
  assign bus.imem_req_valid = !reset && ({1'b0, count} + {1'b0, inflight} < (CW+1)'(DEPTH));
  assign bus.imem_req_addr = fetch_pc;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign resp = bus.imem_resp_valid && inflight != '0;
  assign push = resp && stale == '0 && !bus.redirect;
  assign pop = bus.out_valid && bus.out_ready;
  assign inflight_next = inflight + CW'(accept) - CW'(resp);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC[ADDR_W-1:0];
      resp_pc <= RESET_PC[ADDR_W-1:0];
      inflight <= '0;
      stale <= '0;
    end else begin
      inflight <= inflight_next;
      fetch_pc <= bus.redirect ? bus.redirect_pc : accept ? fetch_pc + ADDR_W'(PC_INC) : fetch_pc;
      resp_pc <= bus.redirect ? bus.redirect_pc : push ? resp_pc + ADDR_W'(PC_INC) : resp_pc;
      // Everything still outstanding after a redirect belongs to the old stream.
      stale <= bus.redirect ? inflight_next : stale - CW'(resp && stale != '0);
    end
  tinker_sync_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .flush(bus.redirect),
    .push(push),
    .din('{pc: PC_W'(resp_pc), instr: IW'(bus.imem_resp_data)}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assign bus.out_valid = count != '0;
  assign bus.out_pc = head.pc[ADDR_W-1:0];
  assign bus.out_instr = head.instr[INSTR_W-1:0];
  assign bus.count = count;
  a_resp_protocol: assert property (@(posedge clk) disable iff (reset)
    bus.imem_resp_valid |-> inflight != '0);
endmodule

// File: tb/tb_tinker_fetch_queue.sv
module tb_tinker_fetch_queue;
  logic clk = 0;
  logic reset = 1;
  int lat = 1;
  int passed = 0;
  int total = 0;
  logic pv [0:7];
  logic [31:0] pd [0:7];

  tinker_fetch_queue_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4)) bus ();
  tinker_fetch_queue #(.RESET_PC(64'h2000), .DEPTH(4), .ADDR_W(64), .INSTR_W(32), .PC_INC(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // Fixed-latency in-order memory: request sampled mid-cycle, answered lat cycles later.
  initial begin
    logic acc;
    logic [63:0] a;
    bus.imem_resp_valid = 0;
    bus.imem_resp_data = 0;
    for (int i = 0; i < 8; i++) begin pv[i] = 0; pd[i] = 0; end
    forever begin
      @(negedge clk);
      #2;
      acc = !reset && bus.imem_req_valid && bus.imem_req_ready;
      a = bus.imem_req_addr;
      @(posedge clk);
      #1;
      for (int i = 0; i < 7; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
      pv[7] = 0;
      if (reset) for (int i = 0; i < 8; i++) pv[i] = 0;
      else if (acc) begin pv[lat-1] = 1; pd[lat-1] = mem_data(a); end
      bus.imem_resp_valid = pv[0];
      bus.imem_resp_data = pd[0];
    end
  end

  task automatic do_reset(input int l);
    reset = 1;
    lat = l;
    bus.redirect = 0;
    bus.redirect_pc = 0;
    bus.out_ready = 0;
    bus.imem_req_ready = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    bus.redirect = 0;
    bus.redirect_pc = 0;
    bus.out_ready = 0;
    bus.imem_req_ready = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.imem_req_valid, bus.out_valid, bus.count} !== 5'b0)
      $display("FAIL reset_outputs got req_valid=%0b out_valid=%0b count=%0d want 0/0/0",
               bus.imem_req_valid, bus.out_valid, bus.count);
    else passed++;
    reset = 0;
    #1;
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2000)
      $display("FAIL reset_first_req got valid=%0b addr=%h want 1 0x2000", bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
  endtask

  task automatic test_sequential;
    logic [63:0] exp_pc;
    do_reset(1);
    bus.out_ready = 1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2000 + 64'(4 * k))
        $display("FAIL seq_req k=%0d got valid=%0b addr=%h want 1 %h", k, bus.imem_req_valid,
                 bus.imem_req_addr, 64'h2000 + 64'(4 * k));
      else passed++;
      exp_pc = 64'h2000 + 64'(4 * (k - 2));
      total++;
      if (k == 1) begin
        if (bus.out_valid !== 1'b0) $display("FAIL seq_not_yet got out_valid=%0b want 0", bus.out_valid);
        else passed++;
      end else if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, exp_pc, mem_data(exp_pc)})
        $display("FAIL seq_out k=%0d got valid=%0b pc=%h instr=%h want 1 %h %h", k, bus.out_valid,
                 bus.out_pc, bus.out_instr, exp_pc, mem_data(exp_pc));
      else passed++;
    end
  endtask

  task automatic test_full;
    int n = 0;
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) n++;
    end
    total++;
    if (n != 4) $display("FAIL full_accepts got %0d want 4", n);
    else passed++;
    total++;
    if (bus.imem_req_valid !== 1'b0 || bus.count !== 3'd4 || bus.out_pc !== 64'h2000)
      $display("FAIL full_stall got req_valid=%0b count=%0d pc=%h want 0 4 0x2000",
               bus.imem_req_valid, bus.count, bus.out_pc);
    else passed++;
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    total++;
    if (bus.count !== 3'd3 || bus.out_pc !== 64'h2004)
      $display("FAIL full_pop got count=%0d pc=%h want 3 0x2004", bus.count, bus.out_pc);
    else passed++;
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2010)
      $display("FAIL full_reenable got valid=%0b addr=%h want 1 0x2010", bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.imem_req_valid !== 1'b0) $display("FAIL full_one_credit got req_valid=%0b want 0", bus.imem_req_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.count !== 3'd4 || bus.imem_req_valid !== 1'b0)
      $display("FAIL full_refill got count=%0d req_valid=%0b want 4 0", bus.count, bus.imem_req_valid);
    else passed++;
  endtask

  task automatic test_redirect;
    do_reset(3);
    repeat (5) @(negedge clk);
    total++;
    if (bus.count !== 3'd2) $display("FAIL redir_pre_count got %0d want 2", bus.count);
    else passed++;
    bus.redirect = 1;
    bus.redirect_pc = 64'h3000;
    @(negedge clk);
    bus.redirect = 0;
    bus.out_ready = 1;
    total++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
      $display("FAIL redir_flush got count=%0d out_valid=%0b want 0 0", bus.count, bus.out_valid);
    else passed++;
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h3000)
      $display("FAIL redir_req got valid=%0b addr=%h want 1 0x3000", bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0)
        $display("FAIL redir_drop k=%0d got out_valid=%0b pc=%h want 0", k, bus.out_valid, bus.out_pc);
      else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 64'h3000 + 64'(4 * k), mem_data(64'h3000 + 64'(4 * k))})
        $display("FAIL redir_new k=%0d got valid=%0b pc=%h instr=%h want 1 %h", k, bus.out_valid,
                 bus.out_pc, bus.out_instr, 64'h3000 + 64'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_collision;
    do_reset(1);
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    bus.redirect = 1;
    bus.redirect_pc = 64'h4000;
    @(negedge clk);
    bus.redirect = 0;
    total++;
    if (dut.stale !== 3'd1 || dut.inflight !== 3'd1)
      $display("FAIL coll_stale got stale=%0d inflight=%0d want 1 1", dut.stale, dut.inflight);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_addr !== 64'h4000)
      $display("FAIL coll_flush got out_valid=%0b addr=%h want 0 0x4000", bus.out_valid, bus.imem_req_addr);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL coll_old_pc got out_valid=%0b pc=%h want 0", bus.out_valid, bus.out_pc);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 64'h4000 + 64'(4 * k), mem_data(64'h4000 + 64'(4 * k))})
        $display("FAIL coll_new k=%0d got valid=%0b pc=%h instr=%h want 1 %h", k, bus.out_valid,
                 bus.out_pc, bus.out_instr, 64'h4000 + 64'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_wrap;
    do_reset(1);
    bus.out_ready = 1;
    @(negedge clk);
    bus.redirect = 1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    bus.redirect = 0;
    total++;
    if (bus.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_req0 got %h want fffffffffffffffc", bus.imem_req_addr);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0)
      $display("FAIL wrap_req1 got valid=%0b addr=%h want 1 0", bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_out0 got valid=%0b pc=%h want 1 fffffffffffffffc", bus.out_valid, bus.out_pc);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 64'h0, mem_data(64'h0)})
      $display("FAIL wrap_out1 got valid=%0b pc=%h instr=%h want 1 0 %h", bus.out_valid, bus.out_pc,
               bus.out_instr, mem_data(64'h0));
    else passed++;
  endtask

  task automatic test_async_reset;
    do_reset(3);
    repeat (5) @(negedge clk);
    total++;
    if (bus.count !== 3'd2 || bus.out_valid !== 1'b1)
      $display("FAIL areset_pre got count=%0d out_valid=%0b want 2 1", bus.count, bus.out_valid);
    else passed++;
    reset = 1;
    #1;
    total++;
    if ({bus.out_valid, bus.imem_req_valid, bus.count} !== 5'b0)
      $display("FAIL areset_now got out_valid=%0b req_valid=%0b count=%0d want 0 0 0",
               bus.out_valid, bus.imem_req_valid, bus.count);
    else passed++;
    @(negedge clk);
    reset = 0;
    bus.out_ready = 1;
    #1;
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2000 || bus.count !== 3'd0)
      $display("FAIL areset_restart got valid=%0b addr=%h count=%0d want 1 0x2000 0",
               bus.imem_req_valid, bus.imem_req_addr, bus.count);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 64'h2000, mem_data(64'h2000)})
      $display("FAIL areset_first got valid=%0b pc=%h instr=%h want 1 0x2000", bus.out_valid,
               bus.out_pc, bus.out_instr);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_full;
    test_redirect;
    test_collision;
    test_wrap;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
